peak_detector_adaptive: RTL
===========================

PEAK_DETECTOR_ADAPTIVE -- requirements
Module: peak_detector_adaptive

Interface
REQ-001 SHALL have parameter IN_DW, default 32, meaning unsigned sample width.
REQ-002 SHALL have parameter WINDOW_LEN, default 8, meaning moving-average length (power of 2, at least 2).
REQ-003 SHALL have parameter SEARCH_LEN, default 4, meaning samples scanned for the local maximum, trigger sample included (at least 1).
REQ-004 SHALL have parameter HOLDOFF_LEN, default 16, meaning samples ignored after a report (0 allowed).
REQ-005 SHALL have parameter FACTOR_DW, default 8, meaning threshold-factor width, unsigned Q(FACTOR_DW-4).4.
REQ-006 SHALL have parameter POS_DW, default 16, meaning sample-position counter width.
REQ-007 SHALL have port clk_i, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-008 SHALL have port reset_i, input, 1, meaning reset, asynchronous and active-high.
REQ-009 SHALL have port s_axis_in_tdata, input, IN_DW, meaning the sample.
REQ-010 SHALL have port s_axis_in_tvalid, input, 1, meaning the sample is valid; there is no backpressure.
REQ-011 SHALL have port factor_i, input, FACTOR_DW, meaning the threshold factor (0x10 = 1.0).
REQ-012 SHALL have port peak_valid_o, output, 1, meaning a one-cycle peak report.
REQ-013 SHALL have port peak_score_o, output, IN_DW, meaning the peak minus the local average, saturated at 0.
REQ-014 SHALL have port peak_pos_o, output, POS_DW, meaning the position of the peak sample.
REQ-015 SHALL have port busy_o, output, 1, meaning high in SEARCH or HOLDOFF.

Function
REQ-016 All state SHALL advance only on cycles with s_axis_in_tvalid=1 ("accepted sample"); with tvalid=0, state and outputs hold, except peak_valid_o, which returns to 0.
REQ-017 The position counter SHALL start at 0, increment per accepted sample and wrap modulo 2^POS_DW.
REQ-018 Running sum, width IN_DW+log2(WINDOW_LEN): per accepted sample, sum <= sum + x - oldest; a WINDOW_LEN-deep delay line holds the samples.
REQ-019 avg SHALL be the sum of the WINDOW_LEN samples preceding x, shifted right by log2(WINDOW_LEN), with x excluded.
REQ-020 thr SHALL be (avg * factor_i) >> 4, computed at full width with no truncation before the compare; the compare SHALL be strict (x > thr).
REQ-021 The FSM SHALL have states FILL, IDLE, SEARCH and HOLDOFF.
REQ-022 FILL: there SHALL be no detection; after the WINDOW_LEN-th accepted sample the FSM SHALL go to IDLE.
REQ-023 IDLE: if x > thr, then best=x, best_pos=pos, best_avg=avg and cnt=1.
REQ-024 IDLE trigger: if SEARCH_LEN=1, the block SHALL report; otherwise it SHALL go to SEARCH.
REQ-025 SEARCH: per sample, if x > best (strict, so a tie keeps the earliest sample), best, best_pos and best_avg SHALL update; cnt SHALL increment.
REQ-026 SEARCH: when cnt reaches SEARCH_LEN, the block SHALL report.
REQ-027 Report: peak_valid_o=1 for exactly the cycle after the completing sample, with peak_score_o = best - best_avg (0 if negative) and peak_pos_o = best_pos.
REQ-028 Report: the FSM SHALL go to HOLDOFF, or to IDLE if HOLDOFF_LEN=0.
REQ-029 HOLDOFF: the threshold SHALL be ignored; after HOLDOFF_LEN accepted samples the FSM SHALL go to IDLE.
REQ-030 The window sum SHALL update in every state, including SEARCH and HOLDOFF.
REQ-031 factor_i SHALL be sampled only at the IDLE compare; changes at other times SHALL have no effect.
REQ-032 peak_score_o and peak_pos_o SHALL hold their values until the next report.

Reset
REQ-033 On reset_i=1, immediately and without a clock: outputs 0, sum 0, delay line 0, position 0, counters 0, state FILL.
REQ-034 On reset release, operation SHALL resume from the first accepted sample.
REQ-035 Reset during SEARCH or HOLDOFF SHALL discard the pending report.

Verification (W=8, SEARCH_LEN=4, HOLDOFF_LEN=16, factor_i=0x40)
REQ-036 Basic peak: 8x10, then 100,50,200,30 -> peak_valid_o one cycle after 30, score=174 (200-(210>>3)), pos=10.
REQ-037 Fill suppression: 1000 at sample 5 of fill -> no peak_valid_o; busy_o=0.
REQ-038 Hold-off: repeat the REQ-036 stream, then 1000 within the next 16 samples -> ignored; 1000 after 16 hold-off samples over a settled baseline -> reported.
REQ-039 tvalid gaps: REQ-036 stream with tvalid low every other cycle -> identical score and pos; pulse still one cycle long.
REQ-040 Tie and saturation: factor_i=0x08 with search samples 100,100 -> pos of the first 100; a peak below avg -> score 0.
REQ-041 Reset mid-SEARCH: reset_i pulse after 100 -> all outputs 0 at once, no pulse, FILL restarts; a further 8 samples are required before any detection.

Source files
------------

// File: rtl/peak_detector_adaptive.sv
// Adaptive peak detector: moving-average baseline, scaled threshold trigger,
// local-maximum search window and hold-off after each report.
module peak_detector_adaptive #(
    parameter int unsigned IN_DW       = 32,
    parameter int unsigned WINDOW_LEN  = 8,
    parameter int unsigned SEARCH_LEN  = 4,
    parameter int unsigned HOLDOFF_LEN = 16,
    parameter int unsigned FACTOR_DW   = 8,
    parameter int unsigned POS_DW      = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [IN_DW-1:0]     s_axis_in_tdata,
    input  logic                 s_axis_in_tvalid,
    input  logic [FACTOR_DW-1:0] factor_i,
    output logic                 peak_valid_o,
    output logic [IN_DW-1:0]     peak_score_o,
    output logic [POS_DW-1:0]    peak_pos_o,
    output logic                 busy_o
);

    localparam int unsigned LOG2W   = $clog2(WINDOW_LEN);
    localparam int unsigned SUM_DW  = IN_DW + LOG2W;
    localparam int unsigned PROD_DW = IN_DW + FACTOR_DW;
    localparam int unsigned MAX_SH  = (SEARCH_LEN > HOLDOFF_LEN) ? SEARCH_LEN : HOLDOFF_LEN;
    localparam int unsigned CNT_MAX = (WINDOW_LEN > MAX_SH) ? WINDOW_LEN : MAX_SH;
    localparam int unsigned CNT_DW  = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        FILL,
        IDLE,
        SEARCH,
        HOLDOFF
    } state_t;

    state_t             state_q, state_d;
    logic [IN_DW-1:0]   dline_q [WINDOW_LEN];
    logic [SUM_DW-1:0]  sum_q;
    logic [POS_DW-1:0]  pos_q;
    logic [CNT_DW-1:0]  cnt_q, cnt_d;
    logic [IN_DW-1:0]   best_q, best_d;
    logic [IN_DW-1:0]   best_avg_q, best_avg_d;
    logic [POS_DW-1:0]  best_pos_q, best_pos_d;
    logic               report;
    logic [IN_DW-1:0]   avg;
    logic [PROD_DW-1:0] prod;
    logic [PROD_DW-1:0] thr;
    logic               above_thr;
    logic [IN_DW-1:0]   score;

    // sum_q covers the WINDOW_LEN samples before the current one, so x is excluded
    assign avg       = IN_DW'(sum_q >> LOG2W);
    assign prod      = PROD_DW'(avg) * PROD_DW'(factor_i);
    assign thr       = prod >> 4;
    assign above_thr = PROD_DW'(s_axis_in_tdata) > thr;
    assign busy_o    = (state_q == SEARCH) || (state_q == HOLDOFF);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        best_d     = best_q;
        best_avg_d = best_avg_q;
        best_pos_d = best_pos_q;
        report     = 1'b0;

        case (state_q)
            FILL: begin
                if (cnt_q == CNT_DW'(WINDOW_LEN - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            IDLE: begin
                if (above_thr) begin
                    best_d     = s_axis_in_tdata;
                    best_pos_d = pos_q;
                    best_avg_d = avg;
                    if (SEARCH_LEN == 1) begin
                        report = 1'b1;
                    end else begin
                        cnt_d   = CNT_DW'(1);
                        state_d = SEARCH;
                    end
                end
            end
            SEARCH: begin
                if (s_axis_in_tdata > best_q) begin
                    best_d     = s_axis_in_tdata;
                    best_pos_d = pos_q;
                    best_avg_d = avg;
                end
                if (cnt_q == CNT_DW'(SEARCH_LEN - 1)) begin
                    report = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLDOFF: begin
                if (cnt_q == CNT_DW'(HOLDOFF_LEN - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = FILL;
            end
        endcase

        if (report) begin
            cnt_d   = '0;
            state_d = (HOLDOFF_LEN == 0) ? IDLE : HOLDOFF;
        end
    end

    // Score uses the post-update best so a maximum on the completing sample counts
    assign score = (best_d > best_avg_d) ? (best_d - best_avg_d) : '0;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= FILL;
            cnt_q        <= '0;
            sum_q        <= '0;
            pos_q        <= '0;
            best_q       <= '0;
            best_avg_q   <= '0;
            best_pos_q   <= '0;
            peak_valid_o <= 1'b0;
            peak_score_o <= '0;
            peak_pos_o   <= '0;
            for (int unsigned i = 0; i < WINDOW_LEN; i++) begin
                dline_q[i] <= '0;
            end
        end else begin
            peak_valid_o <= s_axis_in_tvalid & report;
            if (s_axis_in_tvalid) begin
                state_q    <= state_d;
                cnt_q      <= cnt_d;
                best_q     <= best_d;
                best_avg_q <= best_avg_d;
                best_pos_q <= best_pos_d;
                pos_q      <= pos_q + 1'b1;
                sum_q      <= sum_q + SUM_DW'(s_axis_in_tdata) - SUM_DW'(dline_q[WINDOW_LEN-1]);
                dline_q[0] <= s_axis_in_tdata;
                for (int unsigned i = 1; i < WINDOW_LEN; i++) begin
                    dline_q[i] <= dline_q[i-1];
                end
                if (report) begin
                    peak_score_o <= score;
                    peak_pos_o   <= best_pos_d;
                end
            end
        end
    end

endmodule
